// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the PC-link UART receive and transmit paths.
//   - rx_state_e      : receiver FSM state encoding
//   - CLK_FREQ_DEF    : default system clock frequency (Hz)
//   - BAUD_DEF        : default line rate
//   - bit_cycles()    : clocks per bit, integer floor of clk_freq/baud
//   - half_cycles()   : clocks from start-edge detection to start-bit sample
// Both directions call the same helpers so their bit timing cannot drift apart.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF = 50_000_000;
  localparam int unsigned BAUD_DEF     = 9600;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_cycles(input int unsigned clk_freq,
                                              input int unsigned baud);
    return bit_cycles(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Two-flop synchroniser for the asynchronous RS232 input followed by a
// one-flop delay used for falling-edge detection.
// Ports:
//   clk_i      in   system clock
//   rst_ni     in   synchronous active-low reset
//   rx_i       in   asynchronous serial line (idle high)
//   rx_sync_o  out  synchronised line level
//   fall_o     out  high while a 1->0 transition is visible on rx_sync_o
// All flops reset to 1 (line idle) so leaving reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_o
);

  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_sync_o = rx_sync_q;
  assign fall_o    = rx_prev_q & ~rx_sync_q;

endmodule

// File: rtl/uart_pc_rx.sv
// uart_pc_rx
// Serial receiver for the PC link. Detects the start bit, samples eight data
// bits LSB-first at mid-bit with its own baud counter, checks the stop bit and
// presents each good byte with a one-cycle strobe.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   rs232_rx   in   asynchronous serial input, idle high
//   rx_data    out  last correctly received byte, held until the next good one
//   rx_int     out  one-cycle strobe: rx_data has just been updated
//   frame_err  out  one-cycle strobe: stop bit sampled low, byte discarded
//   rx_busy    out  high whenever the FSM is not in IDLE
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge
// START | counting to mid start bit, then confirming it is still low
// DATA  | sampling data bits one bit period apart, LSB first
// STOP  | sampling the stop bit; high publishes the byte, low flags error
// BREAK | line held low after a framing error; wait for it to go high
module uart_pc_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
  parameter int unsigned BAUD     = BAUD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned BIT_CYC = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned HALF    = half_cycles(CLK_FREQ, BAUD);
  localparam int          CNT_W   = $clog2(BIT_CYC);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(BIT_CYC - 1);

  logic rx_sync;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rx_i      (rs232_rx),
    .rx_sync_o (rx_sync),
    .fall_o    (rx_fall)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_int_q, rx_int_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_int_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_int_q    <= rx_int_d;
      frame_err_q <= frame_err_d;
    end
  end

  // The counter restarts on every state entry and after every data-bit
  // sample, so each compare measures time from the previous sample point.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_int_d    = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d = '0;
          if (!rx_sync) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            // Start bit gone by mid-bit: treat as a glitch.
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_TC) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_TC) begin
          cnt_d = '0;
          if (rx_sync) begin
            rx_data_d = shift_q;
            rx_int_d  = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        // Holding here keeps a stuck-low line from retriggering START.
        if (rx_sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_int    = rx_int_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: doc/uart_pc_rx.md
# uart_pc_rx

- Serial receiver for the PC link: the opposite direction of the existing transmit path.
- Synchronises the RS232 input line, detects the start bit, samples 8 data bits LSB-first at mid-bit using its own baud counter, and checks the stop bit.
- Presents each good byte on `rx_data` with a one-cycle `rx_int` strobe; the transmit/echo path and command parser consume that strobe directly.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate.
- `BIT_CYC`, CLK_FREQ/BAUD (5208): clocks per bit, integer floor; derived, not overridden.
- `HALF`, BIT_CYC/2 (2604): clocks from start-edge detection to start-bit sample; derived.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  synchronous, active-low reset; one clock, reset sampled on the `clk` rising edge.
- `rs232_rx`  in  1  asynchronous serial input; idle high.
- `rx_data`  out  8  last correctly received byte; held until the next good byte.
- `rx_int`  out  1  one-cycle strobe: `rx_data` has just been updated.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low, byte discarded.
- `rx_busy`  out  1  high in any state other than IDLE.

## Operation
- Input conditioning:
  - Two-flop synchroniser `rx_meta` → `rx_sync`, then `rx_prev` delay.
  - Falling edge = `rx_prev`==1 and `rx_sync`==0.
  - All three flops reset to 1.
- Bit counter: `cnt`, width $clog2(BIT_CYC). Cleared on every state entry; increments every clock otherwise.
- Bit index: `bit_idx`, 3 bits.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on falling edge → START.
  - START: at `cnt`==HALF-1, sample `rx_sync`.
    - Low → DATA, `bit_idx`=0.
    - High → IDLE. Glitch; no strobe.
  - DATA: at `cnt`==BIT_CYC-1, shift `rx_sync` into `shift[7]` (right shift, LSB arrives first).
    - `bit_idx`==7 → STOP; otherwise increment `bit_idx`.
  - STOP: at `cnt`==BIT_CYC-1, sample `rx_sync`.
    - High → `rx_data`<=`shift`, `rx_int`<=1, → IDLE.
    - Low → `frame_err`<=1, `rx_data` unchanged, → BREAK.
  - BREAK: wait until `rx_sync`==1, then → IDLE. Prevents a held-low line from re-triggering.
- Strobes are registered. They default to 0 every cycle they are not set.
- Reset values:
  - `rx_data`=8'h00, `rx_int`=0, `frame_err`=0, `rx_busy`=0.
  - State IDLE, `cnt`=0, `bit_idx`=0, `shift`=0.
- Reset mid-frame: the partial byte is discarded and no strobe is issued. After release, the remaining bits of that frame may be mistaken for a start bit. This is accepted; the frame error is recovered by BREAK.
- A falling edge while in START/DATA/STOP is ignored.
- Back-to-back frames are supported: a new start bit is accepted in the cycle immediately after returning to IDLE.

## Timing
- Call the first clock edge at which `rs232_rx` is sampled low edge 0.
  - `rx_sync` is low after edge 1.
  - START is entered at edge 2.
- Start-bit sample: edge 2+HALF.
- Data bit i (i=0..7) sample: edge 2+HALF+(i+1)·BIT_CYC.
- Stop sample: edge 2+HALF+9·BIT_CYC.
  - `rx_int` or `frame_err` is high for exactly the one cycle after that edge.
  - `rx_data` changes on the same edge `rx_int` rises.
- `rx_busy` rises after edge 2. It falls on the stop-sample edge (good frame) or on BREAK exit.
- Baud tolerance: sampling stays within ±(HALF/BIT_CYC)/10 of bit centre over the frame, giving about ±4% total clock/baud mismatch.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, BREAK);
  - default `CLK_FREQ`/`BAUD` constants;
  - `BIT_CYC`/`HALF` derivation function, so the transmit side uses identical constants.
- One natural sub-module: `uart_rx_sync`, the 2-flop synchroniser plus edge detector.
- FSM, counters and shift register stay in `uart_pc_rx`.

## Test plan
- Reset held 5 cycles while `rs232_rx`=0, then released with line high → all outputs 0 / 8'h00; no strobe while the line stays high.
- Frame 0x55 at 9600 baud from idle → `rx_int` one cycle at the computed edge, `rx_data`=8'h55, `frame_err`=0; then frames 0xA3 and 0x00 back-to-back with zero idle bits → two strobes, values 8'hA3 and 8'h00.
- Low glitch of 1000 clocks (< HALF) on an idle line → no `rx_int`/`frame_err`, `rx_busy` returns low at edge 2+HALF.
- Frame 0x3C with stop bit driven low, line then held low 3 bit times → `frame_err` one cycle, `rx_data` keeps its previous value, no new start accepted until the line returns high; next valid frame 0x81 → `rx_data`=8'h81.
- Transmitter clock skewed +3% and −3%, random bytes ×256 → every byte received correctly, no `frame_err`.
- `rst_n` pulsed low for 1 cycle mid-DATA of frame 0xFF → no strobe for that frame; a following clean frame 0x12 after ≥1 idle frame time → `rx_data`=8'h12.
